timer_bank: RTL

//  Multi-channel programmable interval timer replacing the single fixed 1 s tick generator.
//  A shared prescaler divides clk down to a base strobe of TICK_HZ.
//  NUM_CH independent channels each count base strobes up to a programmable period.

---
 rtl/timer_bank.sv | 139 +++++++++++++
 1 files changed

// File: rtl/timer_bank.sv
// timer_bank: multi-channel programmable interval timer.
// A shared prescaler divides clk down to a TICK_HZ base strobe. Each channel
// counts base strobes up to its own period, in periodic or one-shot mode, and
// raises a one-cycle tick plus a sticky irq when the period expires.
module timer_bank #(
    parameter int FREQUENCY = 100_000_000,
    parameter int TICK_HZ   = 1_000,
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 32,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    enable,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic                    cfg_mode,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       irq_clr,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       irq,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH*CNT_W-1:0] count
);

    localparam int PRESCALE = FREQUENCY / TICK_HZ;
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [PRE_W-1:0] pre_cnt;
    logic             strobe;

    // Shared prescaler: free-runs while enabled, wraps at PRESCALE-1.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt <= '0;
        end else if (enable) begin
            if (pre_cnt == PRE_LAST) pre_cnt <= '0;
            else                     pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Base strobe: last prescaler count of an enabled cycle (every cycle when PRESCALE==1).
    assign strobe = enable && (pre_cnt == PRE_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] shd_period;
        logic             shd_mode;
        logic [CNT_W-1:0] act_period_q, act_period_d;
        logic             act_mode_q, act_mode_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        state_t           state_q, state_d;
        logic             expire;
        logic             tick_q;
        logic             irq_q;

        // Shadow config; a channel select with no matching channel writes nothing.
        always_ff @(posedge clk or posedge rst_i) begin
            if (rst_i) begin
                shd_period <= '0;
                shd_mode   <= 1'b0;
            end else if (cfg_we && (cfg_ch == CH_W'(i))) begin
                shd_period <= cfg_period;
                shd_mode   <= cfg_mode;
            end
        end

        // Channel state, active config and counter registers.
        always_ff @(posedge clk or posedge rst_i) begin
            if (rst_i) begin
                state_q      <= IDLE;
                act_period_q <= '0;
                act_mode_q   <= 1'b0;
                cnt_q        <= '0;
            end else begin
                state_q      <= state_d;
                act_period_q <= act_period_d;
                act_mode_q   <= act_mode_d;
                cnt_q        <= cnt_d;
            end
        end

        // Next-state logic with priority stop > start > strobe.
        always_comb begin
            state_d      = state_q;
            act_period_d = act_period_q;
            act_mode_d   = act_mode_q;
            cnt_d        = cnt_q;
            expire       = 1'b0;
            if (stop[i]) begin
                state_d = IDLE;
            end else if (start[i] && (shd_period != '0)) begin
                act_period_d = shd_period;
                act_mode_d   = shd_mode;
                cnt_d        = '0;
                state_d      = RUN;
            end else if ((state_q == RUN) && strobe) begin
                if (cnt_q == act_period_q - CNT_W'(1)) begin
                    cnt_d  = '0;
                    expire = 1'b1;
                    if (act_mode_q) begin
                        state_d = IDLE;
                    end else if (shd_period != '0) begin
                        // A zero shadow period would never expire, so the
                        // previous active config is kept in that case.
                        act_period_d = shd_period;
                        act_mode_d   = shd_mode;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Registered tick pulse and sticky irq (set wins over clear).
        always_ff @(posedge clk or posedge rst_i) begin
            if (rst_i) begin
                tick_q <= 1'b0;
                irq_q  <= 1'b0;
            end else begin
                tick_q <= expire;
                irq_q  <= expire | (irq_q & ~irq_clr[i]);
            end
        end

        assign tick[i]                    = tick_q;
        assign irq[i]                     = irq_q;
        assign running[i]                 = (state_q == RUN);
        assign count[i*CNT_W +: CNT_W]    = cnt_q;
    end

endmodule
